// File: rtl/mna_inject_arbiter.sv
// Two-requester NoC injection arbiter: round-robin packet grant,
// VC allocation at packet start, registered single-flit output stage.
module mna_inject_arbiter #(
  parameter int          FLIT_W      = 37,
  parameter int          VC_N        = 8,
  parameter logic [15:0] PKT_CNT_RST = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [FLIT_W-1:0] req_data0,
  input  logic [FLIT_W-1:0] req_data1,
  input  logic [1:0]        req_last,
  output logic [1:0]        req_ready,
  input  logic [VC_N-1:0]   is_on_off,
  input  logic [VC_N-1:0]   is_allocatable,
  output logic [FLIT_W-1:0] noc_data,
  output logic              is_valid,
  output logic [VC_N-1:0]   vc_sel,
  output logic [1:0]        grant,
  output logic [15:0]       pkt_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]        state;
  logic              ptr;
  logic [VC_N-1:0]   avail;
  logic [VC_N-1:0]   avail_low;
  logic              win_idx;
  logic              gidx;
  logic              vc_on;
  logic              xfer;
  logic              tail;
  logic [FLIT_W-1:0] flit;

  assign avail     = is_allocatable & is_on_off;
  assign avail_low = avail & (~avail + VC_N'(1));

  // A lone requester wins outright; the pointer breaks ties only.
  always_comb begin
    win_idx = ptr;
    unique case (1'b1)
      req_valid == 2'b01: win_idx = 1'b0;
      req_valid == 2'b10: win_idx = 1'b1;
      default:            win_idx = ptr;
    endcase
  end

  assign gidx  = grant[1];
  assign vc_on = |(is_on_off & vc_sel);
  assign flit  = gidx ? req_data1 : req_data0;
  assign tail  = req_last[gidx];

  always_comb begin
    req_ready = 2'b00;
    if (state == SEND && !reset)
      req_ready = grant & {2{vc_on}};
  end

  assign xfer = |(req_valid & req_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      noc_data  <= '0;
      is_valid  <= 1'b0;
      vc_sel    <= '0;
      grant     <= 2'b00;
      pkt_count <= PKT_CNT_RST;
    end else begin
      is_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid && |avail) begin
            state  <= SEND;
            grant  <= win_idx ? 2'b10 : 2'b01;
            vc_sel <= avail_low;
          end
        end
        SEND: begin
          if (xfer) begin
            noc_data <= flit;
            is_valid <= 1'b1;
            if (tail) begin
              state     <= IDLE;
              grant     <= 2'b00;
              vc_sel    <= '0;
              pkt_count <= pkt_count + 16'd1;
              ptr       <= ~gidx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
